sa_00: RTL and testbench

Switch allocator for the corner router at node 00. Each cycle it takes the routed requests from the three input ports: Local, East and South. Each request carries a 4-bit direction from that port's route-compute stage. The block grants each output port to at most one input, using per-output round-robin, and tracks downstream buffer credits. It drives the crossbar selects and the per-port pop strobes, and exports downstream occupancy as the pressure values that route compute uses for adaptive routing.

---
 rtl/sa_00_pkg.sv | 36 +++
 rtl/sa_rr_arb3.sv | 47 ++++
 rtl/sa_00.sv | 143 ++++++++++++++
 tb/tb_sa_00.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_00_pkg.sv
// Shared constants and helpers for the node-00 switch allocator (sa_00, sa_rr_arb3).
package sa_00_pkg;

  localparam logic [3:0] DIR_LOCAL = 4'b0000;
  localparam logic [3:0] DIR_SOUTH = 4'b0001;
  localparam logic [3:0] DIR_EAST  = 4'b0010;
  localparam logic [3:0] DIR_NONE  = 4'b1111;

  localparam int P_L = 0;
  localparam int P_E = 1;
  localparam int P_S = 2;

  typedef enum logic [1:0] {
    OUT_L    = 2'd0,
    OUT_E    = 2'd1,
    OUT_S    = 2'd2,
    OUT_NONE = 2'd3
  } out_e;

  function automatic out_e decode_dir(input logic [3:0] dir);
    case (dir)
      DIR_LOCAL: return OUT_L;
      DIR_SOUTH: return OUT_S;
      DIR_EAST:  return OUT_E;
      DIR_NONE:  return OUT_NONE;
      default:   return OUT_NONE;
    endcase
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    if (oh[2]) return 2'd2;
    if (oh[1]) return 2'd1;
    return 2'd0;
  endfunction

endpackage

// File: rtl/sa_rr_arb3.sv
// Three-requester round-robin arbiter; the pointer holds the last winner and the
// search starts one past it. Grant is combinational, the pointer registered.
module sa_rr_arb3
  import sa_00_pkg::*;
(
  input  logic       rc_clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       en,
  output logic [2:0] gnt
);

  logic [1:0] ptr;

  always_comb begin
    gnt = '0;
    if (en) begin
      case (ptr)
        2'd0: begin
          if (req[1])      gnt = 3'b010;
          else if (req[2]) gnt = 3'b100;
          else if (req[0]) gnt = 3'b001;
        end
        2'd1: begin
          if (req[2])      gnt = 3'b100;
          else if (req[0]) gnt = 3'b001;
          else if (req[1]) gnt = 3'b010;
        end
        default: begin
          if (req[0])      gnt = 3'b001;
          else if (req[1]) gnt = 3'b010;
          else if (req[2]) gnt = 3'b100;
        end
      endcase
    end
  end

  // Reset to 2 so input 0 (Local) is searched first.
  always_ff @(posedge rc_clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'd2;
    end else if (|gnt) begin
      ptr <= onehot_to_idx(gnt);
    end
  end

endmodule

// File: rtl/sa_00.sv
// Switch allocator for corner router node 00 (inputs/outputs L, E, S).
// Define SA_00_CREDIT_EN to build the East/South downstream credit counters.
module sa_00
  import sa_00_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3
) (
  input  logic             rc_clk,
  input  logic             rst_n,
  input  logic             req_valid_l,
  input  logic             req_valid_e,
  input  logic             req_valid_s,
  input  logic [3:0]       req_dir_l,
  input  logic [3:0]       req_dir_e,
  input  logic [3:0]       req_dir_s,
  input  logic             credit_in_e,
  input  logic             credit_in_s,
  input  logic             out_ready_l,
  output logic             grant_l,
  output logic             grant_e,
  output logic             grant_s,
  output logic [1:0]       sel_l,
  output logic [1:0]       sel_e,
  output logic [1:0]       sel_s,
  output logic             out_valid_l,
  output logic             out_valid_e,
  output logic             out_valid_s,
  output logic             drop,
  output logic [WIDTH:0]   E_pressure_out,
  output logic [WIDTH:0]   S_pressure_out
);

  localparam logic [WIDTH:0] DEPTH_C = (WIDTH + 1)'(DEPTH);

  // Handshake: an input port holds req_valid/req_dir until it sees a one-cycle
  // grant pulse, which is its pop; the held grant masks that input for one cycle
  // so the flit being popped is never granted twice.
  logic [2:0] grant_q;
  logic [2:0] valid_v;
  logic [2:0] eligible;
  logic [2:0] unroute;
  logic [2:0] req_l, req_e, req_s;
  logic [2:0] gnt_l, gnt_e, gnt_s;
  logic [3:0] dir_v [3];
  logic       avail_l, avail_e, avail_s;

  assign valid_v[P_L] = req_valid_l;
  assign valid_v[P_E] = req_valid_e;
  assign valid_v[P_S] = req_valid_s;
  assign dir_v[P_L]   = req_dir_l;
  assign dir_v[P_E]   = req_dir_e;
  assign dir_v[P_S]   = req_dir_s;
  assign eligible     = valid_v & ~grant_q;

  always_comb begin
    req_l   = '0;
    req_e   = '0;
    req_s   = '0;
    unroute = '0;
    for (int i = 0; i < 3; i++) begin
      case (decode_dir(dir_v[i]))
        OUT_L:   req_l[i]   = eligible[i];
        OUT_E:   req_e[i]   = eligible[i];
        OUT_S:   req_s[i]   = eligible[i];
        default: unroute[i] = eligible[i];
      endcase
    end
  end

  assign avail_l = out_ready_l;

`ifdef SA_00_CREDIT_EN
  logic [WIDTH:0] credit_e, credit_s;

  assign avail_e = (credit_e != '0);
  assign avail_s = (credit_s != '0);

  // A return and a consume in the same cycle cancel; returns saturate at DEPTH.
  always_ff @(posedge rc_clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_e <= DEPTH_C;
      credit_s <= DEPTH_C;
    end else begin
      if ((|gnt_e) && !credit_in_e) begin
        credit_e <= credit_e - 1'b1;
      end else if (!(|gnt_e) && credit_in_e && (credit_e != DEPTH_C)) begin
        credit_e <= credit_e + 1'b1;
      end
      if ((|gnt_s) && !credit_in_s) begin
        credit_s <= credit_s - 1'b1;
      end else if (!(|gnt_s) && credit_in_s && (credit_s != DEPTH_C)) begin
        credit_s <= credit_s + 1'b1;
      end
    end
  end

  assign E_pressure_out = DEPTH_C - credit_e;
  assign S_pressure_out = DEPTH_C - credit_s;
`else
  logic           unused_credit;
  logic [WIDTH:0] unused_depth;

  assign unused_credit  = credit_in_e ^ credit_in_s;
  assign unused_depth   = DEPTH_C;
  assign avail_e        = 1'b1;
  assign avail_s        = 1'b1;
  assign E_pressure_out = '0;
  assign S_pressure_out = '0;
`endif

  sa_rr_arb3 u_arb_l (.rc_clk(rc_clk), .rst_n(rst_n), .req(req_l), .en(avail_l), .gnt(gnt_l));
  sa_rr_arb3 u_arb_e (.rc_clk(rc_clk), .rst_n(rst_n), .req(req_e), .en(avail_e), .gnt(gnt_e));
  sa_rr_arb3 u_arb_s (.rc_clk(rc_clk), .rst_n(rst_n), .req(req_s), .en(avail_s), .gnt(gnt_s));

  // Unroutable requests are popped and discarded without touching any output.
  always_ff @(posedge rc_clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q     <= '0;
      out_valid_l <= 1'b0;
      out_valid_e <= 1'b0;
      out_valid_s <= 1'b0;
      sel_l       <= 2'd0;
      sel_e       <= 2'd0;
      sel_s       <= 2'd0;
      drop        <= 1'b0;
    end else begin
      grant_q     <= gnt_l | gnt_e | gnt_s | unroute;
      out_valid_l <= |gnt_l;
      out_valid_e <= |gnt_e;
      out_valid_s <= |gnt_s;
      drop        <= |unroute;
      if (|gnt_l) sel_l <= onehot_to_idx(gnt_l);
      if (|gnt_e) sel_e <= onehot_to_idx(gnt_e);
      if (|gnt_s) sel_s <= onehot_to_idx(gnt_s);
    end
  end

  assign grant_l = grant_q[P_L];
  assign grant_e = grant_q[P_E];
  assign grant_s = grant_q[P_S];

endmodule

// File: tb/tb_sa_00.sv
// Bench for sa_00: directed steps then random traffic, checked against a
// cycle-level reference model of the allocation rules (either SA_00_CREDIT_EN build).
module tb_sa_00;
  import sa_00_pkg::*;

  localparam int DEPTH = 8;
  localparam int WIDTH = 3;
  localparam int VW    = 21;

  logic             rc_clk = 1'b0;
  logic             rst_n  = 1'b0;
  logic             req_valid_l = 0, req_valid_e = 0, req_valid_s = 0;
  logic [3:0]       req_dir_l = 0, req_dir_e = 0, req_dir_s = 0;
  logic             credit_in_e = 0, credit_in_s = 0, out_ready_l = 0;
  logic             grant_l, grant_e, grant_s;
  logic [1:0]       sel_l, sel_e, sel_s;
  logic             out_valid_l, out_valid_e, out_valid_s, drop;
  logic [WIDTH:0]   E_pressure_out, S_pressure_out;

  int total = 0;
  int bad   = 0;

  logic [VW-1:0] exp_q[$];

  int         m_rr[3];
  int         m_cred[3];
  logic [2:0] m_gnt;

  sa_00 #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .rc_clk(rc_clk), .rst_n(rst_n),
    .req_valid_l(req_valid_l), .req_valid_e(req_valid_e), .req_valid_s(req_valid_s),
    .req_dir_l(req_dir_l), .req_dir_e(req_dir_e), .req_dir_s(req_dir_s),
    .credit_in_e(credit_in_e), .credit_in_s(credit_in_s), .out_ready_l(out_ready_l),
    .grant_l(grant_l), .grant_e(grant_e), .grant_s(grant_s),
    .sel_l(sel_l), .sel_e(sel_e), .sel_s(sel_s),
    .out_valid_l(out_valid_l), .out_valid_e(out_valid_e), .out_valid_s(out_valid_s),
    .drop(drop), .E_pressure_out(E_pressure_out), .S_pressure_out(S_pressure_out)
  );

  // Clock and reset
  always #5 rc_clk = ~rc_clk;

  function automatic int dest_of(input logic [3:0] d);
    case (d)
      4'b0000: return 0;
      4'b0010: return 1;
      4'b0001: return 2;
      default: return -1;
    endcase
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {grant_s, grant_e, grant_l, out_valid_s, out_valid_e, out_valid_l,
            sel_s, sel_e, sel_l, drop, E_pressure_out, S_pressure_out};
  endfunction

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < 3; o++) begin
      m_rr[o]   = 2;
      m_cred[o] = DEPTH;
    end
    m_gnt = '0;
    exp_q.delete();
  endtask

  // Reference model: apply the allocation rules to the inputs present this cycle.
  task automatic model_step();
    logic [3:0] d[3];
    logic       v[3];
    logic       cin[3];
    bit         avail[3];
    bit         elig[3];
    logic [2:0] g, ov;
    logic [1:0] sl[3];
    logic       dr;
    logic [3:0] ep, sp;
    int         i;
    d   = '{req_dir_l, req_dir_e, req_dir_s};
    v   = '{req_valid_l, req_valid_e, req_valid_s};
    cin = '{1'b0, credit_in_e, credit_in_s};
    avail[0] = out_ready_l;
`ifdef SA_00_CREDIT_EN
    avail[1] = m_cred[1] > 0;
    avail[2] = m_cred[2] > 0;
`else
    avail[1] = 1'b1;
    avail[2] = 1'b1;
`endif
    g = '0; ov = '0; dr = 1'b0;
    sl = '{2'd0, 2'd0, 2'd0};
    for (int k = 0; k < 3; k++) begin
      elig[k] = v[k] && !m_gnt[k];
      if (elig[k] && dest_of(d[k]) < 0) begin
        g[k] = 1'b1;
        dr   = 1'b1;
      end
    end
    for (int o = 0; o < 3; o++) begin
      if (avail[o]) begin
        for (int k = 1; k <= 3; k++) begin
          i = (m_rr[o] + k) % 3;
          if (elig[i] && dest_of(d[i]) == o) begin
            g[i]    = 1'b1;
            ov[o]   = 1'b1;
            sl[o]   = 2'(i);
            m_rr[o] = i;
            break;
          end
        end
      end
    end
`ifdef SA_00_CREDIT_EN
    for (int o = 1; o < 3; o++) begin
      if (ov[o] && !cin[o]) m_cred[o] = m_cred[o] - 1;
      else if (!ov[o] && cin[o] && m_cred[o] < DEPTH) m_cred[o] = m_cred[o] + 1;
    end
    ep = 4'(DEPTH - m_cred[1]);
    sp = 4'(DEPTH - m_cred[2]);
`else
    if (cin[1] || cin[2]) begin end
    ep = '0;
    sp = '0;
`endif
    m_gnt = g;
    exp_q.push_back({g, ov, sl[2], sl[1], sl[0], dr, ep, sp});
  endtask

  // Driver tasks
  task automatic drive(input logic vl, input logic [3:0] dl, input logic ve, input logic [3:0] de,
                       input logic vs, input logic [3:0] ds, input logic ce, input logic cs,
                       input logic rdy);
    req_valid_l = vl; req_dir_l = dl;
    req_valid_e = ve; req_dir_e = de;
    req_valid_s = vs; req_dir_s = ds;
    credit_in_e = ce; credit_in_s = cs;
    out_ready_l = rdy;
  endtask

  task automatic step(input string tag);
    logic [VW-1:0] obs, exp;
    model_step();
    @(posedge rc_clk);
    #1;
    obs = obs_vec();
    exp = exp_q.pop_front();
    if (!exp[17]) obs[14:13] = 2'd0;
    if (!exp[16]) obs[12:11] = 2'd0;
    if (!exp[15]) obs[10:9]  = 2'd0;
    check(tag, obs, exp);
  endtask

  function automatic logic [3:0] rand_dir();
    case ($urandom_range(0, 7))
      0, 1:    return DIR_LOCAL;
      2, 3:    return DIR_SOUTH;
      4, 5:    return DIR_EAST;
      6:       return DIR_NONE;
      default: return 4'($urandom_range(3, 14));
    endcase
  endfunction

  initial begin
    int cnt_l, cnt_s;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) @(posedge rc_clk);
    @(negedge rc_clk);
    rst_n = 1'b1;
    #1;
    check("reset", obs_vec(), '0);

    drive(1, DIR_EAST, 0, 0, 0, 0, 0, 0, 1);
    step("l_to_e");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("idle_a");

    cnt_l = 0; cnt_s = 0;
    drive(1, DIR_SOUTH, 0, 0, 1, DIR_SOUTH, 0, 0, 1);
    for (int n = 0; n < 6; n++) begin
      step("rr_s");
      cnt_l += int'(grant_l);
      cnt_s += int'(grant_s);
    end
    check("rr_balance", VW'({cnt_l[7:0], cnt_s[7:0]}), VW'({8'd3, 8'd3}));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("idle_b");

    drive(0, 0, 1, DIR_NONE, 0, 0, 0, 0, 1);
    step("unr_1111");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("idle_c");
    drive(0, 0, 1, 4'b0101, 0, 0, 0, 0, 1);
    step("unr_0101");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("idle_d");

    drive(0, 0, 1, DIR_EAST, 1, DIR_LOCAL, 1, 0, 0);
    step("lbp_hold1");
    step("lbp_hold2");
    out_ready_l = 1'b1;
    step("lbp_go");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("idle_e");

`ifdef SA_00_CREDIT_EN
    drive(1, DIR_EAST, 0, 0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 24; n++) step("exhaust");
    credit_in_e = 1'b1;
    step("credit_ret");
    credit_in_e = 1'b0;
    for (int n = 0; n < 6; n++) step("after_ret");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("idle_f");
`endif

    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        rst_n = 1'b0;
        #2;
        check("mid_reset", obs_vec(), '0);
        model_reset();
        @(negedge rc_clk);
        rst_n = 1'b1;
      end
      drive(1'($urandom_range(0, 1)), rand_dir(), 1'($urandom_range(0, 1)), rand_dir(),
            1'($urandom_range(0, 1)), rand_dir(), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0));
      step("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
